// File: rtl/fan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_pkg                                                                    |
// | Shared fan speed codes, driver FSM state encodings and duty width.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fan_pkg;

    localparam int DUTY_W = 8;

    localparam logic [1:0] FAN_OFF  = 2'b00;
    localparam logic [1:0] FAN_LOW  = 2'b01;
    localparam logic [1:0] FAN_MED  = 2'b10;
    localparam logic [1:0] FAN_HIGH = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KICK  = 3'd1;
    localparam logic [2:0] ST_RAMP  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fan_tach_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_tach_monitor                                                           |
// | Tach synchroniser, rising-edge detect and stall timer.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fan_tach_monitor
    import fan_pkg::*;
#(
    parameter int STALL_TIMEOUT = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tach,
    input  logic i_active,
    output logic o_stall
);

    localparam logic [15:0] c_timeout = 16'(STALL_TIMEOUT);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [15:0] r_quiet;
    logic        w_edge;

    assign w_edge = r_sync2 & ~r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_quiet <= '0;
        end else begin
            r_sync1 <= i_tach;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!i_active || w_edge) begin
                r_quiet <= '0;
            end else if (r_quiet < c_timeout) begin
                r_quiet <= r_quiet + 16'd1;
            end
        end
    end

    // A tach edge arriving on the timeout cycle rescues the fan.
    assign o_stall = i_active && !w_edge && (r_quiet >= c_timeout);

endmodule
`default_nettype wire

// File: rtl/fan_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fan_pwm_driver                                                             |
// | Fan PWM generator with spin-up kick, rate-limited ramp and stall fault.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fan_pwm_driver
    import fan_pkg::*;
#(
    parameter int PWM_PERIOD    = 100,
    parameter int DUTY_LOW      = 30,
    parameter int DUTY_MED      = 60,
    parameter int DUTY_HIGH     = 100,
    parameter int KICK_CYCLES   = 5000,
    parameter int RAMP_DIV      = 64,
    parameter int RAMP_STEP     = 1,
    parameter int STALL_TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              speed_set,
    input  logic [1:0]        fan_speed,
    input  logic              tach_in,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              ramping,
    output logic              fan_fault
);

    localparam int KICK_W = $clog2(KICK_CYCLES + 1);
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);

    localparam logic [DUTY_W-1:0] c_period      = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] c_period_last = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] c_step        = DUTY_W'(RAMP_STEP);
    localparam logic [DUTY_W:0]   c_step_w      = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [KICK_W-1:0] c_kick_last   = KICK_W'(KICK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  c_div_last    = DIV_W'(RAMP_DIV - 1);

    logic [DUTY_W-1:0] r_target;
    logic [2:0]        r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [KICK_W-1:0] r_kick_cnt;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_ramping;
    logic              r_fault;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic [DUTY_W-1:0] r_duty_applied;
    logic              r_pwm;

    logic              w_active;
    logic              w_stall;
    logic              w_go_safe;
    logic              w_div_tick;
    logic [DUTY_W:0]   w_up;
    logic [DUTY_W:0]   w_gap;
    logic [DUTY_W-1:0] w_next_duty;

    function automatic logic [DUTY_W-1:0] code_to_duty(input logic [1:0] code);
        case (code)
            FAN_LOW:  return DUTY_W'(DUTY_LOW);
            FAN_MED:  return DUTY_W'(DUTY_MED);
            FAN_HIGH: return DUTY_W'(DUTY_HIGH);
            default:  return '0;
        endcase
    endfunction

    fan_tach_monitor #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_tach (
        .clk      (clk),
        .rst      (reset),
        .i_tach   (tach_in),
        .i_active (w_active),
        .o_stall  (w_stall)
    );

    assign w_active   = (r_state == ST_KICK) || (r_state == ST_RAMP) || (r_state == ST_RUN);
    assign w_go_safe  = (r_target == '0) || w_stall || (r_state == ST_FAULT);
    assign w_div_tick = (r_div_cnt == c_div_last);

    // Step arithmetic is one bit wider so a step-up near 255 cannot wrap.
    always_comb begin
        w_up        = {1'b0, r_duty} + c_step_w;
        w_gap       = {1'b0, r_duty} - {1'b0, r_target};
        w_next_duty = r_duty;
        if (w_div_tick) begin
            if (r_duty < r_target) begin
                w_next_duty = (w_up > {1'b0, r_target}) ? r_target : w_up[DUTY_W-1:0];
            end else if (r_duty > r_target) begin
                w_next_duty = (w_gap <= c_step_w) ? r_target : (r_duty - c_step);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_target   <= '0;
            r_state    <= ST_IDLE;
            r_duty     <= '0;
            r_kick_cnt <= '0;
            r_div_cnt  <= '0;
            r_ramping  <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            if (speed_set) begin
                r_target <= code_to_duty(fan_speed);
            end
            if (w_active && (r_target == '0)) begin
                r_state   <= ST_IDLE;
                r_duty    <= '0;
                r_ramping <= 1'b0;
            end else if (w_stall) begin
                r_state   <= ST_FAULT;
                r_duty    <= '0;
                r_ramping <= 1'b0;
                r_fault   <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_duty <= '0;
                        if (r_target != '0) begin
                            r_state    <= ST_KICK;
                            r_kick_cnt <= '0;
                            r_duty     <= c_period;
                            r_ramping  <= 1'b1;
                        end
                    end
                    ST_KICK: begin
                        if (r_kick_cnt == c_kick_last) begin
                            r_state   <= ST_RAMP;
                            r_div_cnt <= '0;
                        end else begin
                            r_kick_cnt <= r_kick_cnt + 1'b1;
                        end
                    end
                    ST_RAMP: begin
                        r_div_cnt <= w_div_tick ? '0 : (r_div_cnt + 1'b1);
                        r_duty    <= w_next_duty;
                        if (w_next_duty == r_target) begin
                            r_state   <= ST_RUN;
                            r_ramping <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        if (r_duty != r_target) begin
                            r_state   <= ST_RAMP;
                            r_div_cnt <= '0;
                            r_ramping <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        r_duty  <= '0;
                        r_fault <= 1'b1;
                        if (r_target == '0) begin
                            r_state <= ST_IDLE;
                            r_fault <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_duty    <= '0;
                        r_ramping <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Duty is only picked up at the period wrap so no runt pulse reaches the pad.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt      <= '0;
            r_duty_applied <= '0;
            r_pwm          <= 1'b0;
        end else begin
            r_pwm_cnt <= (r_pwm_cnt == c_period_last) ? '0 : (r_pwm_cnt + 1'b1);
            if (w_go_safe) begin
                r_duty_applied <= '0;
                r_pwm          <= 1'b0;
            end else begin
                r_pwm <= (r_pwm_cnt < r_duty_applied);
                if (r_pwm_cnt == c_period_last) begin
                    r_duty_applied <= r_duty;
                end
            end
        end
    end

    assign pwm_out   = r_pwm;
    assign duty_cur  = r_duty;
    assign ramping   = r_ramping;
    assign fan_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fan_pwm_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fan_pwm_driver                                                          |
// | Directed and randomized bench against a behavioural fan driver model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fan_pwm_driver;

    localparam int P      = 10;
    localparam int D_LOW  = 3;
    localparam int D_MED  = 6;
    localparam int D_HIGH = 10;
    localparam int KICK   = 20;
    localparam int DIV    = 2;
    localparam int STEP   = 1;
    localparam int TMO    = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       speed_set;
    logic [1:0] fan_speed;
    logic       tach_in;
    logic       pwm_out;
    logic [7:0] duty_cur;
    logic       ramping;
    logic       fan_fault;

    fan_pwm_driver #(
        .PWM_PERIOD    (P),
        .DUTY_LOW      (D_LOW),
        .DUTY_MED      (D_MED),
        .DUTY_HIGH     (D_HIGH),
        .KICK_CYCLES   (KICK),
        .RAMP_DIV      (DIV),
        .RAMP_STEP     (STEP),
        .STALL_TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .speed_set (speed_set),
        .fan_speed (fan_speed),
        .tach_in   (tach_in),
        .pwm_out   (pwm_out),
        .duty_cur  (duty_cur),
        .ramping   (ramping),
        .fan_fault (fan_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: fan spinning/kick/settled flags plus time-based counters.
    int       m_target, m_duty, m_kick_left, m_ramp_t, m_quiet, m_pwm_t, m_applied;
    bit       m_spin, m_settled, m_fault, m_pwm, m_ramping;
    bit [2:0] m_hist;

    int tach_period;
    int tach_cnt;

    function automatic int code_duty(input logic [1:0] code);
        case (code)
            2'b01:   return D_LOW;
            2'b10:   return D_MED;
            2'b11:   return D_HIGH;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit edge_seen, stall, safe;
        int t;
        if (reset) begin
            m_target = 0; m_duty = 0; m_kick_left = 0; m_ramp_t = 0; m_quiet = 0;
            m_pwm_t = 0; m_applied = 0; m_spin = 0; m_settled = 0; m_fault = 0;
            m_pwm = 0; m_hist = '0;
        end else begin
            t         = m_target;
            edge_seen = m_hist[1] && !m_hist[2];
            stall     = m_spin && !edge_seen && (m_quiet >= TMO);
            safe      = (t == 0) || stall || m_fault;

            m_pwm = safe ? 1'b0 : (m_pwm_t < m_applied);
            if (safe) m_applied = 0;
            else if (m_pwm_t == P - 1) m_applied = m_duty;
            m_pwm_t = (m_pwm_t + 1) % P;

            if (!m_spin || edge_seen) m_quiet = 0;
            else if (m_quiet < TMO) m_quiet++;

            if (m_fault) begin
                if (t == 0) m_fault = 0;
            end else if (!m_spin) begin
                if (t != 0) begin
                    m_spin = 1; m_kick_left = KICK; m_duty = P; m_settled = 0;
                end
            end else if (t == 0) begin
                m_spin = 0; m_kick_left = 0; m_duty = 0;
            end else if (stall) begin
                m_spin = 0; m_kick_left = 0; m_duty = 0; m_fault = 1;
            end else if (m_kick_left > 0) begin
                m_kick_left--;
                m_ramp_t = 0;
            end else if (!m_settled) begin
                m_ramp_t++;
                if (m_ramp_t == DIV) begin
                    m_ramp_t = 0;
                    if (m_duty < t) m_duty = (m_duty + STEP > t) ? t : m_duty + STEP;
                    else m_duty = (m_duty - STEP < t) ? t : m_duty - STEP;
                end
                if (m_duty == t) m_settled = 1;
            end else if (m_duty != t) begin
                m_settled = 0;
                m_ramp_t  = 0;
            end

            if (speed_set) m_target = code_duty(fan_speed);
            m_hist = {m_hist[1:0], tach_in};
        end
        m_ramping = m_spin && (m_kick_left > 0 || !m_settled);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pwm_out", pwm_out, m_pwm);
        check("duty_cur", duty_cur, m_duty);
        check("ramping", ramping, m_ramping);
        check("fan_fault", fan_fault, m_fault);
        if (tach_period == 0) begin
            tach_in  = 1'b0;
            tach_cnt = 0;
        end else begin
            tach_cnt++;
            if (tach_cnt >= tach_period) begin
                tach_cnt = 0;
                tach_in  = ~tach_in;
            end
        end
    endtask

    task automatic set_speed(input logic [1:0] code);
        speed_set = 1'b1;
        fan_speed = code;
        cycle();
        speed_set = 1'b0;
        fan_speed = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_settled(input string tag, input int want);
        int n = 0;
        while (!(ramping == 1'b0 && duty_cur == 8'(want)) && n < 300) begin
            cycle();
            n++;
        end
        check(tag, duty_cur, want);
        check({tag, "_ramping"}, ramping, 0);
    endtask

    initial begin
        int hi;
        int n;
        int len;
        reset = 1'b1; speed_set = 1'b0; fan_speed = 2'b00; tach_in = 1'b0;
        tach_period = 8; tach_cnt = 0;
        repeat (3) cycle();
        reset = 1'b0;
        check("reset_pwm", pwm_out, 0);
        check("reset_duty", duty_cur, 0);
        check("reset_fault", fan_fault, 0);

        // Spin up to low: kick at full duty, then ramp down to 3.
        set_speed(2'b01);
        cycle();
        check("kick_duty", duty_cur, P);
        check("kick_ramping", ramping, 1);
        wait_settled("run_low", D_LOW);
        repeat (12) cycle();
        hi = 0;
        for (int i = 0; i < P; i++) begin
            cycle();
            hi += int'(pwm_out);
        end
        check("low_high_count", hi, D_LOW);

        // Code change without qualifier is ignored; with it the duty ramps up.
        speed_set = 1'b0;
        fan_speed = 2'b10;
        repeat (10) cycle();
        check("hold_duty", duty_cur, D_LOW);
        set_speed(2'b10);
        cycle();
        cycle();
        check("ramp_up_flag", ramping, 1);
        wait_settled("run_med", D_MED);

        // Reset while running.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_run_pwm", pwm_out, 0);
        check("rst_run_duty", duty_cur, 0);
        check("rst_run_fault", fan_fault, 0);

        // Stall: tach held low while spinning.
        set_speed(2'b11);
        repeat (30) cycle();
        tach_period = 0;
        n = 0;
        while (fan_fault !== 1'b1 && n < 300) begin
            cycle();
            n++;
        end
        check("stall_fault", fan_fault, 1);
        cycle();
        check("stall_pwm", pwm_out, 0);
        set_speed(2'b11);
        repeat (5) cycle();
        check("fault_sticky", fan_fault, 1);
        set_speed(2'b00);
        cycle();
        check("fault_clear", fan_fault, 0);

        // Stop requested during kick.
        tach_period = 8;
        set_speed(2'b11);
        repeat (6) cycle();
        set_speed(2'b00);
        cycle();
        check("kick_stop_pwm", pwm_out, 0);
        check("kick_stop_duty", duty_cur, 0);
        check("kick_stop_fault", fan_fault, 0);

        // Randomized traffic against the model.
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 4))
                0:       tach_period = 0;
                1:       tach_period = 3;
                2:       tach_period = 8;
                3:       tach_period = 12;
                default: tach_period = 20;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                cycle();
                reset = 1'b0;
            end
            set_speed(2'($urandom_range(0, 3)));
            len = $urandom_range(20, 120);
            for (int i = 0; i < len; i++) begin
                fan_speed = 2'($urandom_range(0, 3));
                speed_set = ($urandom_range(0, 39) == 0);
                cycle();
            end
            speed_set = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
